// File: rtl/nx_token_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// NXConstants
// Purpose : shared constants and types for the column token scheduler.
// Contents: TOKEN_TIMEOUT_DEFAULT - default watchdog limit in HOLD cycles
//           token_sched_state_t   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package NXConstants;

  localparam int TOKEN_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } token_sched_state_t;

endpackage

// File: rtl/nx_find_next_set.sv
// -----------------------------------------------------------------------------
// nx_find_next_set
// Purpose : combinational search for the lowest set mask bit whose position is
//           at or above a start index.
// Ports   : mask_i  - candidate mask
//           start_i - start index, one bit wider than a node index; the top bit
//                     set means the search space is exhausted
//           idx_o   - index of the bit found (0 when none)
//           found_o - a bit was found
// -----------------------------------------------------------------------------
module nx_find_next_set
  import NXConstants::*;
#(
  parameter int REQUESTERS = 8
) (
  input  logic [REQUESTERS-1:0]         mask_i,
  input  logic [$clog2(REQUESTERS):0]   start_i,
  output logic [$clog2(REQUESTERS)-1:0] idx_o,
  output logic                          found_o
);

  localparam int SW = $clog2(REQUESTERS);
  localparam int IW = SW + 1;

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (mask_i[i] && (IW'(i) >= start_i)) begin
        idx_o   = SW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nx_token_scheduler.sv
// -----------------------------------------------------------------------------
// nx_token_scheduler
// Purpose : passes the shared outbound channel token to every present node of a
//           mesh column in ascending index order, one holder at a time.
// Macro   : NX_TOKEN_TIMEOUT_EN - adds a watchdog that revokes a holder after
//           TIMEOUT HOLD cycles and flags it on timeout_o.
// Ports   : clk_i      - clock
//           rst_i      - synchronous active-high reset
//           trigger_i  - start a round (ignored and flagged while busy)
//           present_i  - node present mask, sampled with the trigger
//           release_i  - per-node release pulses
//           grant_o    - registered one-hot/zero token grant
//           busy_o     - round in progress
//           done_o     - one-cycle end-of-round pulse
//           overrun_o  - sticky: trigger seen while busy
//           timeout_o  - sticky: holder revoked by the watchdog
// -----------------------------------------------------------------------------
module nx_token_scheduler
  import NXConstants::*;
#(
  parameter int REQUESTERS = 8,
  parameter int TIMEOUT    = TOKEN_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trigger_i,
  input  logic [REQUESTERS-1:0] present_i,
  input  logic [REQUESTERS-1:0] release_i,
  output logic [REQUESTERS-1:0] grant_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int SW = $clog2(REQUESTERS);
  localparam int IW = SW + 1;

  token_sched_state_t    state_q, state_d;
  logic [REQUESTERS-1:0] mask_q, mask_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [SW-1:0]         next_idx;
  logic                  next_found;
  logic                  hold_rel;
  logic                  revoke;

  nx_find_next_set #(
    .REQUESTERS(REQUESTERS)
  ) u_find (
    .mask_i  (mask_q),
    .start_i (idx_q),
    .idx_o   (next_idx),
    .found_o (next_found)
  );

  // In HOLD idx_q holds the current holder, so only its release bit matters.
  assign hold_rel = release_i[idx_q[SW-1:0]];

`ifdef NX_TOKEN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          cnt_hit;

  // Fires on the HOLD cycle where the count would reach TIMEOUT, so the grant
  // is visible for exactly TIMEOUT cycles.
  assign cnt_hit = (state_q == HOLD) && ((cnt_q + CW'(1)) == CW'(TIMEOUT));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == GRANT) begin
      cnt_d = '0;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q + CW'(1);
    end
    // A release coinciding with the limit wins.
    if (cnt_hit && !hold_rel) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign revoke    = cnt_hit;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign revoke         = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (trigger_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger_i) begin
          mask_d  = present_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (next_found) begin
          grant_d           = '0;
          grant_d[next_idx] = 1'b1;
          idx_d             = {1'b0, next_idx};
          state_d           = HOLD;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      HOLD: begin
        if (hold_rel || revoke) begin
          grant_d               = '0;
          mask_d[idx_q[SW-1:0]] = 1'b0;
          // May carry into the overflow bit, which ends the search.
          idx_d                 = idx_q + IW'(1);
          state_d               = GRANT;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_nx_token_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nx_token_scheduler
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a timeline model built
// from a queue of pending holders and cycle timestamps.
// -----------------------------------------------------------------------------
module tb_nx_token_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef NX_TOKEN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         trigger = 1'b0;
  logic [N-1:0] present = '0;
  logic [N-1:0] rel     = '0;
  logic [N-1:0] grant;
  logic         busy, done, overrun, timeout;

  int n_checks = 0;
  int n_err    = 0;

  nx_token_scheduler #(.REQUESTERS(N), .TIMEOUT(TO)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .trigger_i (trigger),
    .present_i (present),
    .release_i (rel),
    .grant_o   (grant),
    .busy_o    (busy),
    .done_o    (done),
    .overrun_o (overrun),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- timeline model ----------------
  int q[$];
  int m_holder = -1;   // node currently shown on grant, -1 for none
  int m_next   = -1;   // cycle at which the next grant (or done) appears
  int m_hold   = 0;    // cycles the current holder has been visible
  int cyc      = 0;
  bit m_busy = 0, m_done = 0, m_over = 0, m_to = 0;
  bit started = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_holder = -1; m_next = -1; m_hold = 0;
      m_busy = 0; m_done = 0; m_over = 0; m_to = 0;
    end else begin
      bit was_done;
      bit nb;
      was_done = m_done;
      nb       = m_busy;
      m_done   = 0;
      if (trigger) begin
        if (m_busy) m_over = 1;
        else begin
          q.delete();
          for (int b = 0; b < N; b++) if (present[b]) q.push_back(b);
          m_next = cyc + 2;
          nb     = 1;
        end
      end
      if (m_holder >= 0) begin
        m_hold++;
        if (rel[m_holder] || (TO_EN && m_hold == TO)) begin
          if (!rel[m_holder]) m_to = 1;
          m_holder = -1;
          m_next   = cyc + 2;
        end
      end
      if (m_next == cyc + 1) begin
        if (q.size() > 0) begin
          m_holder = q.pop_front();
          m_hold   = 0;
        end else begin
          m_done = 1;
        end
        m_next = -1;
      end
      m_busy = was_done ? 1'b0 : nb;
    end
    cyc++;
    started = 1;
  end

  int       done_cnt = 0;
  bit [N-1:0] seen   = '0;

  always @(negedge clk) begin
    if (started) begin
      chk("m_grant",   32'(grant),   (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
      chk("m_busy",    32'(busy),    32'(m_busy));
      chk("m_done",    32'(done),    32'(m_done));
      chk("m_overrun", 32'(overrun), 32'(m_over));
      chk("m_timeout", 32'(timeout), 32'(m_to));
      if (done) done_cnt++;
      seen |= grant;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic start(input logic [N-1:0] mask);
    present = mask;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  // Called on the first cycle the node's grant is visible; releases on the
  // hold-th visible cycle and lands on the dead cycle.
  task automatic hold_release(input int node, input int hold);
    repeat (hold - 1) begin
      chk("hold", 32'(grant), 32'd1 << node);
      step();
    end
    rel[node] = 1'b1;
    step();
    rel = '0;
    chk("gap", 32'(grant), 32'd0);
  endtask

  initial begin
    int d0;
    step(); step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", 32'({overrun, timeout}), 0);
    rst = 1'b0;
    step();

    // Round over 1011, 3-cycle holds.
    d0 = done_cnt; seen = '0;
    start(4'b1011);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_nogrant", 32'(grant), 0);
    step();
    chk("t1_g0", 32'(grant), 32'b0001);
    hold_release(0, 3); step();
    chk("t1_g1", 32'(grant), 32'b0010);
    hold_release(1, 3); step();
    chk("t1_g3", 32'(grant), 32'b1000);
    hold_release(3, 3); step();
    chk("t1_done", 32'(done), 1);
    step();
    chk("t1_idle", 32'({busy, done}), 0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_no_node2", 32'(seen & 4'b0100), 0);

    // Empty mask.
    start(4'b0000);
    chk("t2_busy1", 32'({busy, done, grant}), 32'h20);
    step();
    chk("t2_done", 32'({busy, done, grant}), 32'h30);
    step();
    chk("t2_idle", 32'(busy), 0);

    // Foreign release ignored.
    start(4'b0101); step();
    chk("t4_g0", 32'(grant), 32'b0001);
    rel[2] = 1'b1; step(); step(); rel = '0;
    chk("t4_keep", 32'(grant), 32'b0001);
    hold_release(0, 1); step();
    chk("t4_g2", 32'(grant), 32'b0100);
    hold_release(2, 2); step();
    chk("t4_done", 32'(done), 1);
    step();

    // Trigger during a hold.
    start(4'b0111); step();
    hold_release(0, 1); step();
    chk("t3_g1", 32'(grant), 32'b0010);
    present = 4'b1111; trigger = 1'b1; step(); trigger = 1'b0;
    chk("t3_over", 32'(overrun), 1);
    hold_release(1, 1); step();
    chk("t3_g2", 32'(grant), 32'b0100);
    hold_release(2, 1); step();
    chk("t3_done", 32'(done), 1);
    step(); step();
    chk("t3_sticky", 32'({overrun, busy}), 32'b10);

    // Reset mid-round, then fresh round.
    start(4'b0011); step();
    hold_release(0, 1); step();
    chk("t6_g1", 32'(grant), 32'b0010);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst", 32'({grant, busy, done, overrun, timeout}), 0);
    start(4'b0010); step();
    chk("t6_fresh", 32'(grant), 32'b0010);
    hold_release(1, 2); step();
    chk("t6_done", 32'(done), 1);
    step();

    // Holder that never releases.
    start(4'b0011); step();
`ifdef NX_TOKEN_TIMEOUT_EN
    repeat (TO) begin
      chk("t5_hold", 32'(grant), 32'b0001);
      step();
    end
    chk("t5_revoke", 32'(grant), 0);
    chk("t5_flag", 32'(timeout), 1);
    step();
    chk("t5_next", 32'(grant), 32'b0010);
    hold_release(1, 1); step();
`else
    repeat (120) step();
    chk("t5_persist", 32'(grant), 32'b0001);
    chk("t5_noflag", 32'(timeout), 0);
    hold_release(0, 1); step();
    chk("t5_next", 32'(grant), 32'b0010);
    hold_release(1, 1); step();
`endif
    chk("t5_done", 32'(done), 1);
    step();

    // Randomized traffic against the model.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      trigger = ($urandom_range(0, 9) == 0);
      present = N'($urandom);
      for (int b = 0; b < N; b++) rel[b] = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0; trigger = 1'b0; rel = '0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/nx_token_scheduler.md
# nx_token_scheduler

Sequences the shared outbound channel token among the nodes on one mesh column. On each trigger it passes the token in ascending index order to every present node. Each holder keeps the token until it releases it. When the last holder releases, the scheduler reports completion. Each node's `token_grant_i` / `token_release_o` pair connects to one bit of `grant_o` / `release_i`.

## Interface
Parameters:
- `REQUESTERS`, 8: number of nodes sharing the channel. Must be at least 2.
- `TIMEOUT`, 1024: maximum cycles a holder may keep the token. Used only with `NX_TOKEN_TIMEOUT_EN`.

Ports:
- `clk_i`, input, 1: single clock.
- `rst_i`, input, 1: reset; synchronous, active-high.
- `trigger_i`, input, 1: starts a token round.
- `present_i`, input, REQUESTERS: per-node present mask. Sampled on the trigger cycle.
- `release_i`, input, REQUESTERS: per-node token release pulses.
- `grant_o`, output, REQUESTERS: one-hot or zero token grant. Registered.
- `busy_o`, output, 1: round in progress.
- `done_o`, output, 1: one-cycle pulse at the end of a round.
- `overrun_o`, output, 1: sticky; a trigger arrived while busy.
- `timeout_o`, output, 1: sticky; a holder was revoked by the watchdog.

## Operation
- Reset: all outputs 0, state IDLE, stored mask 0, index 0.
- States are IDLE, GRANT, HOLD and DONE.
- IDLE:
  - `trigger_i` latches `present_i` into the mask and moves to GRANT.
  - `release_i` is ignored.
- GRANT:
  - Selects the lowest set mask bit at or above the index and registers `grant_o` for it. Moves to HOLD.
  - If no bit remains, moves to DONE with no grant.
- HOLD:
  - `grant_o` stays stable.
  - When `release_i[idx]` is high: clear `grant_o`, clear that mask bit, set index to idx+1, return to GRANT.
  - Release bits from non-holders are ignored in every state.
- DONE: `done_o` high for one cycle, clear index, return to IDLE.
- `busy_o` is high in GRANT, HOLD and DONE.
- Trigger while busy: ignored and sets `overrun_o`. The current round is unaffected.
- Index arithmetic is `$clog2(REQUESTERS)` wide plus one overflow bit. Overflow means no bits remain. There is no wrap-around within a round.

## Timing
- Trigger at cycle T gives the first `grant_o` at T+2: GRANT is entered at T+1 and the grant is registered at T+2.
- Release sampled at cycle R: grant low at R+1, next grant high at R+2. There is exactly one dead cycle between holders.
- A release in the first cycle the grant is visible is valid.
- Last release at R: `done_o` at R+2, `busy_o` low at R+3, so a new trigger is accepted from R+3.
- Empty mask, trigger at T: `done_o` at T+2 and no grant is ever issued.
- Reset asserted mid-round: at the next edge all state and outputs return to reset values, including the sticky flags.

## Configuration
- Macro: `NX_TOKEN_TIMEOUT_EN`.
- Defined:
  - A hold counter of width `$clog2(TIMEOUT+1)` clears on entry to HOLD and increments every HOLD cycle.
  - When it reaches TIMEOUT without a release, the grant is revoked exactly as for a release, and `timeout_o` is set.
  - A release on the same cycle as the timeout counts as a release; `timeout_o` is not set.
- Undefined: no counter, `timeout_o` tied 0, and HOLD waits indefinitely.

## Structure
- `NXConstants` gains:
  - `TOKEN_TIMEOUT_DEFAULT` (1024).
  - `token_sched_state_t`, the enum of IDLE, GRANT, HOLD and DONE.
- Sub-module `nx_find_next_set`: combinational lowest-set-bit search at or above a start index. Outputs are index and found flag; REQUESTERS is a parameter.
- The rest is a single FSM with registered outputs.

## Test plan
- REQUESTERS=4, mask 4'b1011, trigger, each holder releases 3 cycles after grant: grants go 0, 1, 3 in that order, node 2 is never granted, `done_o` pulses once, and each holder switch shows exactly one gap cycle.
- Mask 0, trigger at T: `done_o` at T+2, `grant_o` stays 0, `busy_o` high T+1 to T+2.
- Trigger while node 1 holds the token: `overrun_o` is set and stays set, and the grant sequence is unchanged.
- A release on node 2 while node 0 holds the token is ignored: node 0 keeps the grant, and node 2 is still granted in order.
- With the macro and TIMEOUT=16, node 0 never releases: the grant is revoked after 16 HOLD cycles, `timeout_o` is set, node 1 is granted two cycles later. Without the macro the grant persists beyond 100 cycles.
- Reset pulsed while node 1 holds the token: next cycle all outputs are 0 and state is IDLE. A following trigger with mask 4'b0010 starts a fresh round with the first grant to node 1.
